// File: rtl/vx_fetch.sv
// vx_fetch -- instruction fetch stage feeding decode.
//
// Keeps a PC, thread mask and active flag for each warp. Each cycle it
// picks the next active warp after the round-robin pointer, presents that
// warp's PC to the I-cache and registers the returned instruction, the PC,
// the thread-valid mask and the warp number into the fetch/decode boundary.
//
// Flow control: there is no valid/ready pair. Decode and the backend signal
// back-pressure through in_stall (freeze, everything holds) and
// in_branch_stall (a control-flow instruction is in flight, so fetch issues
// bubbles until execute returns a resolution). out_valid == 0 marks a bubble.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_stall                freeze outputs and PCs
//   in_branch_stall         enter WAIT_BR, issue bubbles
//   in_ebreak               halt until reset
//   in_wspawn/_pc           start every inactive warp (w >= 1) at _pc
//   in_resolve_*            control-flow resolution from execute
//   in_change_mask/
//   in_thread_mask          replace a warp's mask on resolve (0 = deactivate)
//   in_icache_data          instruction at out_icache_pc (same cycle)
//   out_icache_pc           PC of the selected warp (combinational)
//   out_instruction/out_curr_PC/out_valid/out_warp_num  registered to decode
//   out_busy                low once halted
//   out_perf_*              performance counters (VX_FETCH_PERF_EN only)
//   out_dbg_state           current FSM state (0 RUN, 1 WAIT_BR, 2 HALT)
//
// Optional build macro: VX_FETCH_PERF_EN adds out_perf_fetches and
// out_perf_stall_cycles.
module vx_fetch #(
  parameter int          NW       = 2,
  parameter int          NT       = 2,
  parameter logic [31:0] START_PC = 32'h80000000,
  localparam int         WW       = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_stall,
  input  logic          in_branch_stall,
  input  logic          in_ebreak,
  input  logic          in_wspawn,
  input  logic [31:0]   in_wspawn_pc,
  input  logic          in_resolve_valid,
  input  logic [WW-1:0] in_resolve_warp,
  input  logic          in_resolve_taken,
  input  logic [31:0]   in_resolve_dest,
  input  logic          in_change_mask,
  input  logic [NT-1:0] in_thread_mask,
  input  logic [31:0]   in_icache_data,
  output logic [31:0]   out_icache_pc,
  output logic [31:0]   out_instruction,
  output logic [31:0]   out_curr_PC,
  output logic [NT-1:0] out_valid,
  output logic [WW-1:0] out_warp_num,
  output logic          out_busy,
`ifdef VX_FETCH_PERF_EN
  output logic [31:0]   out_perf_fetches,
  output logic [31:0]   out_perf_stall_cycles,
`endif
  output logic [1:0]    out_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_BR = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] ptr_q, ptr_d;
  logic [31:0]   pc_q   [NW];
  logic [31:0]   pc_d   [NW];
  logic [NT-1:0] mask_q [NW];
  logic [NT-1:0] mask_d [NW];
  logic [NW-1:0] active_q, active_d;

  logic [31:0]   instr_q, instr_d;
  logic [31:0]   cpc_q, cpc_d;
  logic [NT-1:0] valid_q, valid_d;
  logic [WW-1:0] warp_q, warp_d;
  logic          busy_q, busy_d;

  logic [WW-1:0] sel;
  logic          any_active;
  logic          halted;
  logic          ctl_ok;
  logic          issue;

  // Round-robin pick: first active warp at (ptr+1), (ptr+2), ... mod NW.
  always_comb begin
    int idx;
    sel        = '0;
    any_active = 1'b0;
    idx        = 0;
    for (int i = 1; i <= NW; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NW) idx = idx - NW;
      if (!any_active && active_q[idx]) begin
        any_active = 1'b1;
        sel        = WW'(idx);
      end
    end
  end

  assign out_icache_pc = pc_q[sel];

  assign halted = (state_q == ST_HALT);
  // ebreak outranks resolve/wspawn, and nothing but reset leaves HALT.
  assign ctl_ok = !halted && !in_ebreak;
  assign issue  = (state_q == ST_RUN) && !in_stall && !in_branch_stall &&
                  !in_ebreak && any_active;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pc_d     = pc_q;
    mask_d   = mask_q;
    active_d = active_q;
    instr_d  = instr_q;
    cpc_d    = cpc_q;
    valid_d  = valid_q;
    warp_d   = warp_q;

    if (!halted) begin
      if (in_ebreak)             state_d = ST_HALT;
      else if (in_branch_stall)  state_d = ST_WAIT_BR;
      else if (in_resolve_valid) state_d = ST_RUN;
    end

    if (issue) begin
      pc_d[sel] = pc_q[sel] + 32'd4;
      ptr_d     = sel;
    end

    if (ctl_ok && in_wspawn) begin
      for (int w = 1; w < NW; w++) begin
        if (!active_q[w]) begin
          pc_d[w]     = in_wspawn_pc;
          mask_d[w]   = NT'(1);
          active_d[w] = 1'b1;
        end
      end
    end

    // Applied after the issue update so a redirect wins over PC+4.
    if (ctl_ok && in_resolve_valid && (int'(in_resolve_warp) < NW)) begin
      if (in_resolve_taken) pc_d[in_resolve_warp] = in_resolve_dest;
      if (in_change_mask) begin
        mask_d[in_resolve_warp]   = in_thread_mask;
        active_d[in_resolve_warp] = |in_thread_mask;
      end
    end

    // HALT forces bubbles; otherwise a stall freezes the boundary.
    if (halted) begin
      valid_d = '0;
    end else if (!in_stall) begin
      if (issue) begin
        instr_d = in_icache_data;
        cpc_d   = pc_q[sel];
        valid_d = mask_q[sel];
        warp_d  = sel;
      end else begin
        valid_d = '0;
      end
    end

    busy_d = (state_d != ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      ptr_q    <= WW'(NW - 1);
      for (int w = 0; w < NW; w++) begin
        pc_q[w]   <= (w == 0) ? START_PC : 32'd0;
        mask_q[w] <= (w == 0) ? NT'(1) : '0;
      end
      active_q <= NW'(1);
      instr_q  <= '0;
      cpc_q    <= '0;
      valid_q  <= '0;
      warp_q   <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pc_q     <= pc_d;
      mask_q   <= mask_d;
      active_q <= active_d;
      instr_q  <= instr_d;
      cpc_q    <= cpc_d;
      valid_q  <= valid_d;
      warp_q   <= warp_d;
      busy_q   <= busy_d;
    end
  end

  assign out_instruction = instr_q;
  assign out_curr_PC     = cpc_q;
  assign out_valid       = valid_q;
  assign out_warp_num    = warp_q;
  assign out_busy        = busy_q;
  assign out_dbg_state   = state_q;

`ifdef VX_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue)            perf_fetch_q <= perf_fetch_q + 32'd1;
      if (!halted && !issue) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign out_perf_fetches      = perf_fetch_q;
  assign out_perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_fetch.sv
// Directed bench for vx_fetch (NW = 2, NT = 2). A vector table drives one
// cycle per row and checks the decode-boundary registers after the edge;
// hand-written sequences cover reset, HALT persistence and async reset.
module tb_vx_fetch;

  logic        clk;
  logic        reset;
  logic        in_stall;
  logic        in_branch_stall;
  logic        in_ebreak;
  logic        in_wspawn;
  logic [31:0] in_wspawn_pc;
  logic        in_resolve_valid;
  logic        in_resolve_warp;
  logic        in_resolve_taken;
  logic [31:0] in_resolve_dest;
  logic        in_change_mask;
  logic [1:0]  in_thread_mask;
  logic [31:0] in_icache_data;
  logic [31:0] out_icache_pc;
  logic [31:0] out_instruction;
  logic [31:0] out_curr_PC;
  logic [1:0]  out_valid;
  logic        out_warp_num;
  logic        out_busy;
  logic [1:0]  out_dbg_state;
`ifdef VX_FETCH_PERF_EN
  logic [31:0] out_perf_fetches;
  logic [31:0] out_perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vx_fetch #(.NW(2), .NT(2), .START_PC(32'h80000000)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_stall         (in_stall),
    .in_branch_stall  (in_branch_stall),
    .in_ebreak        (in_ebreak),
    .in_wspawn        (in_wspawn),
    .in_wspawn_pc     (in_wspawn_pc),
    .in_resolve_valid (in_resolve_valid),
    .in_resolve_warp  (in_resolve_warp),
    .in_resolve_taken (in_resolve_taken),
    .in_resolve_dest  (in_resolve_dest),
    .in_change_mask   (in_change_mask),
    .in_thread_mask   (in_thread_mask),
    .in_icache_data   (in_icache_data),
    .out_icache_pc    (out_icache_pc),
    .out_instruction  (out_instruction),
    .out_curr_PC      (out_curr_PC),
    .out_valid        (out_valid),
    .out_warp_num     (out_warp_num),
    .out_busy         (out_busy),
`ifdef VX_FETCH_PERF_EN
    .out_perf_fetches      (out_perf_fetches),
    .out_perf_stall_cycles (out_perf_stall_cycles),
`endif
    .out_dbg_state    (out_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // I-cache model: instruction encodes the low PC bits so a wrong PC is visible.
  function automatic logic [31:0] icache_word(input logic [31:0] pc);
    return 32'h00000013 ^ {pc[15:0], 16'h0000};
  endfunction

  assign in_icache_data = icache_word(out_icache_pc);

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall, bstall, ebreak, wspawn;
    logic [31:0] spc;
    logic        rv, rwarp, rtaken, cmask;
    logic [31:0] rdest;
    logic [1:0]  tmask;
    logic [31:0] exp_pc;
    logic [1:0]  exp_valid;
    logic        exp_warp;
    logic        exp_busy;
  } vec_t;

  // ctl = {stall, branch_stall, ebreak, wspawn}; res = {valid, warp, taken, change_mask}
  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] spc,
                              input logic [3:0] res, input logic [31:0] rdest,
                              input logic [1:0] tmask, input logic [31:0] epc,
                              input logic [1:0] evld, input logic ewarp,
                              input logic ebusy);
    vec_t v;
    {v.stall, v.bstall, v.ebreak, v.wspawn} = ctl;
    {v.rv, v.rwarp, v.rtaken, v.cmask}      = res;
    v.spc = spc; v.rdest = rdest; v.tmask = tmask;
    v.exp_pc = epc; v.exp_valid = evld; v.exp_warp = ewarp; v.exp_busy = ebusy;
    return v;
  endfunction

  vec_t vecs [$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_stall = 1'b0; in_branch_stall = 1'b0; in_ebreak = 1'b0;
    in_wspawn = 1'b0; in_wspawn_pc = '0;
    in_resolve_valid = 1'b0; in_resolve_warp = 1'b0; in_resolve_taken = 1'b0;
    in_resolve_dest = '0; in_change_mask = 1'b0; in_thread_mask = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_stall = v.stall; in_branch_stall = v.bstall; in_ebreak = v.ebreak;
    in_wspawn = v.wspawn; in_wspawn_pc = v.spc;
    in_resolve_valid = v.rv; in_resolve_warp = v.rwarp; in_resolve_taken = v.rtaken;
    in_resolve_dest = v.rdest; in_change_mask = v.cmask; in_thread_mask = v.tmask;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_boundary(input string tag, input logic [31:0] epc,
                              input logic [1:0] evld, input logic ewarp,
                              input logic ebusy);
    exp_q.push_back(epc);
    chk({tag, ".pc"}, out_curr_PC);
    exp_q.push_back(icache_word(epc));
    chk({tag, ".instr"}, out_instruction);
    exp_q.push_back({30'd0, evld});
    chk({tag, ".valid"}, {30'd0, out_valid});
    exp_q.push_back({31'd0, ewarp});
    chk({tag, ".warp"}, {31'd0, out_warp_num});
    exp_q.push_back({31'd0, ebusy});
    chk({tag, ".busy"}, {31'd0, out_busy});
  endtask

  task automatic chk_reset_state(input string tag);
    exp_q.push_back(32'h0);        chk({tag, ".instr"}, out_instruction);
    exp_q.push_back(32'h0);        chk({tag, ".pc"}, out_curr_PC);
    exp_q.push_back(32'h0);        chk({tag, ".valid"}, {30'd0, out_valid});
    exp_q.push_back(32'h0);        chk({tag, ".warp"}, {31'd0, out_warp_num});
    exp_q.push_back(32'h1);        chk({tag, ".busy"}, {31'd0, out_busy});
    exp_q.push_back(32'h80000000); chk({tag, ".icache_pc"}, out_icache_pc);
    exp_q.push_back(32'h0);        chk({tag, ".state"}, {30'd0, out_dbg_state});
  endtask

  // ---------------- test ----------------
  initial begin
    // Steady fetch, then a 3-cycle stall.
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000000, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000004, 2'b01, 0, 1));
    vecs.push_back(mk(4'b1000, 0, 4'b0000, 0, 2'b00, 32'h80000004, 2'b01, 0, 1));
    vecs.push_back(mk(4'b1000, 0, 4'b0000, 0, 2'b00, 32'h80000004, 2'b01, 0, 1));
    vecs.push_back(mk(4'b1000, 0, 4'b0000, 0, 2'b00, 32'h80000004, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000008, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h8000000C, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000010, 2'b01, 0, 1));
    // Branch stall, wait, taken resolve to 80000100.
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 2'b00, 32'h80000010, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000010, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b1010, 32'h80000100, 2'b00, 32'h80000010, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000100, 2'b01, 0, 1));
    // Not-taken resolve continues at PC+4.
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 2'b00, 32'h80000100, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b1000, 0, 2'b00, 32'h80000100, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000104, 2'b01, 0, 1));
    // Resolve coincident with branch_stall: applied, but stays in WAIT_BR.
    vecs.push_back(mk(4'b0100, 0, 4'b1010, 32'h80000300, 2'b00, 32'h80000104, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000104, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b1000, 0, 2'b00, 32'h80000104, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000300, 2'b01, 0, 1));
    // Resolve under in_stall: outputs hold, redirect still taken.
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 2'b00, 32'h80000300, 2'b00, 0, 1));
    vecs.push_back(mk(4'b1000, 0, 4'b1010, 32'h80000400, 2'b00, 32'h80000300, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000400, 2'b01, 0, 1));
    // Spawn warp 1, alternate; re-spawn while active has no effect.
    vecs.push_back(mk(4'b0001, 32'h80000200, 4'b0000, 0, 2'b00, 32'h80000404, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000200, 2'b01, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000408, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0001, 32'h80000500, 4'b0000, 0, 2'b00, 32'h80000204, 2'b01, 1, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h8000040C, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000208, 2'b01, 1, 1));
    // Kill warp 1 via mask 00; only warp 0 issues afterwards.
    vecs.push_back(mk(4'b0000, 0, 4'b1101, 0, 2'b00, 32'h80000410, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000414, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000418, 2'b01, 0, 1));
    // Warp 0 mask 11.
    vecs.push_back(mk(4'b0000, 0, 4'b1001, 0, 2'b11, 32'h8000041C, 2'b01, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000420, 2'b11, 0, 1));
    // Kill warp 0 too: no active warp -> bubbles until a spawn revives warp 1.
    vecs.push_back(mk(4'b0000, 0, 4'b1001, 0, 2'b00, 32'h80000424, 2'b11, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000424, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0001, 32'h80000800, 4'b0000, 0, 2'b00, 32'h80000424, 2'b00, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000800, 2'b01, 1, 1));
    // ebreak with branch_stall -> HALT; later resolve/wspawn ignored.
    vecs.push_back(mk(4'b0110, 0, 4'b0000, 0, 2'b00, 32'h80000800, 2'b00, 1, 0));
    vecs.push_back(mk(4'b0001, 32'h80000900, 4'b1110, 32'h80000600, 2'b00, 32'h80000800, 2'b00, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 4'b1001, 0, 2'b11, 32'h80000800, 2'b00, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 2'b00, 32'h80000800, 2'b00, 1, 0));

    // Reset.
    drive_idle();
    reset = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    // Table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      step();
      chk_boundary($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                   vecs[i].exp_warp, vecs[i].exp_busy);
    end
    drive_idle();

    // HALT persists; the ignored resolves left warp 1 at 80000804.
    exp_q.push_back(32'h80000804); chk("halt.icache_pc", out_icache_pc);
    exp_q.push_back(32'h2);        chk("halt.state", {30'd0, out_dbg_state});
    step();
    step();
    chk_boundary("halt.late", 32'h80000800, 2'b00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_boundary("post_reset0", 32'h80000000, 2'b01, 1'b0, 1'b1);
    step();
    chk_boundary("post_reset1", 32'h80000004, 2'b01, 1'b0, 1'b1);

    // Report.
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
